// File: rtl/spc700_pkg.sv
// Shared types and constants for the SPC700 instruction/state sequencer.
// Contents: the stateCtrl microcode field encoding, the sequencer mode
// encoding, special opcodes, datapath widths and the extended-phase step
// mapping helper.
package spc700_pkg;

  localparam int unsigned IR_W    = 8;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned STEP_W  = 3;
  localparam int unsigned CNT_W   = 4;

  // stateCtrl field of the microinstruction
  typedef enum logic [1:0] {
    SC_ADV  = 2'b00,
    SC_END  = 2'b01,
    SC_COND = 2'b10,
    SC_EXT  = 2'b11
  } SpcStateCtrl_t;

  // Sequencer operating modes
  typedef enum logic [1:0] {
    M_NORMAL = 2'b00,
    M_EXT    = 2'b01,
    M_HALT   = 2'b10
  } seq_mode_t;

  localparam logic [IR_W-1:0] OP_MUL   = 8'hCF;
  localparam logic [IR_W-1:0] OP_DIV   = 8'h9E;
  localparam logic [IR_W-1:0] OP_SLEEP = 8'hEF;
  localparam logic [IR_W-1:0] OP_STOP  = 8'hFF;

  // Low STATE bits shown during the extended phase: the last four cycles
  // count up 0..3 so microcode can key its final steps off them.
  function automatic logic [1:0] ext_lo(input logic [CNT_W-1:0] cnt);
    return (cnt <= 4'd3) ? 2'(4'd3 - cnt) : 2'd0;
  endfunction

endpackage

// File: rtl/spc700_ext_cnt.sv
// Extended-phase (MUL/DIV) counter for the SPC700 sequencer.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   en              clock enable (registers hold when low)
//   load            start an extended phase this cycle
//   is_mul          phase length select: 1 = MUL_EXT, 0 = DIV_EXT
//   dec             decrement the counter this cycle
//   step            step to save as the resume point on load
//   saved_step      saved resume step (registered)
//   cnt_zero_c      counter is zero (last extended cycle)
//   lo_next_c       STATE[1:0] to present in the next cycle
module spc700_ext_cnt
  import spc700_pkg::*;
#(
  parameter logic [CNT_W-1:0] MUL_EXT = 4'd5,
  parameter logic [CNT_W-1:0] DIV_EXT = 4'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              load,
  input  logic              is_mul,
  input  logic              dec,
  input  logic [STEP_W-1:0] step,
  output logic [STEP_W-1:0] saved_step,
  output logic              cnt_zero_c,
  output logic [1:0]        lo_next_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter next value: load with length-1 so the phase lasts exactly EXT cycles
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = is_mul ? CNT_W'(MUL_EXT - 4'd1) : CNT_W'(DIV_EXT - 4'd1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  assign cnt_zero_c = (cnt_q == '0);
  assign lo_next_c  = ext_lo(cnt_d);

  // Counter and resume-step registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      saved_step <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
      if (load) begin
        saved_step <= step;
      end
    end
  end

endmodule

// File: rtl/spc700_seq.sv
// SPC700 instruction/state sequencer: owns IR and STATE (the microcode ROM
// index) and chooses the next step from the ROM's stateCtrl field.
// Optional feature macro: SPC700_SLEEP_STOP_EN (SLEEP/STOP halt the sequencer).
// Ports:
//   CLK, RST_N    core clock, async active-low reset
//   EN            clock enable; all registers hold when low
//   STATE_CTRL    stateCtrl field of the current microinstruction
//   DI            data bus in; opcode on end cycles
//   COND          branch/skip condition
//   IR            current opcode
//   STATE         microcode step; bit 3 set during the extended phase
//   SYNC          registered: STATE==0 and not in the extended phase
//   EXT_BUSY      registered: extended MUL/DIV phase active
//   SEQ_ERR       registered one-cycle pulse on step overflow
//   HALTED        sequencer halted by SLEEP/STOP (0 when feature absent)
module spc700_seq
  import spc700_pkg::*;
#(
  parameter logic [IR_W-1:0]  RST_OPCODE = 8'h00,
  parameter logic [CNT_W-1:0] MUL_EXT    = 4'd5,
  parameter logic [CNT_W-1:0] DIV_EXT    = 4'd8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [1:0]         STATE_CTRL,
  input  logic [IR_W-1:0]    DI,
  input  logic               COND,
  output logic [IR_W-1:0]    IR,
  output logic [STATE_W-1:0] STATE,
  output logic               SYNC,
  output logic               EXT_BUSY,
  output logic               SEQ_ERR,
  output logic               HALTED
);

  seq_mode_t            mode_q;
  seq_mode_t            mode_d;
  SpcStateCtrl_t        ctrl;
  logic [IR_W-1:0]      ir_d;
  logic [STATE_W-1:0]   state_d;
  logic                 err_d;
  logic                 is_muldiv_c;
  logic                 want_adv_c;
  logic                 want_ext_c;
  logic                 overflow_c;
  logic                 norm_end_c;
  logic                 halt_c;
  logic                 ext_load_c;
  logic                 ext_dec_c;
  logic [STEP_W-1:0]    saved_step;
  logic                 cnt_zero_c;
  logic [1:0]           lo_next_c;

  // Normal-mode decode of the microinstruction's stateCtrl field
  assign ctrl        = SpcStateCtrl_t'(STATE_CTRL);
  assign is_muldiv_c = (IR == OP_MUL) || (IR == OP_DIV);
  assign want_ext_c  = (ctrl == SC_EXT) && is_muldiv_c;
  assign want_adv_c  = (ctrl == SC_ADV) || ((ctrl == SC_COND) && COND) ||
                       ((ctrl == SC_EXT) && !is_muldiv_c);
  // Advancing past step 7 is forced into an END
  assign overflow_c  = want_adv_c && (STATE[STEP_W-1:0] == 3'd7);
  assign norm_end_c  = (!want_adv_c && !want_ext_c) || overflow_c;

`ifdef SPC700_SLEEP_STOP_EN
  logic is_halt_op_c;
  assign is_halt_op_c = (IR == OP_SLEEP) || (IR == OP_STOP);
  assign halt_c       = norm_end_c && is_halt_op_c;
`else
  assign halt_c       = 1'b0;
`endif

  assign ext_load_c = (mode_q == M_NORMAL) && want_ext_c;
  assign ext_dec_c  = (mode_q == M_EXT) && !cnt_zero_c;

  spc700_ext_cnt #(
    .MUL_EXT (MUL_EXT),
    .DIV_EXT (DIV_EXT)
  ) u_ext_cnt (
    .clk        (CLK),
    .rst_n      (RST_N),
    .en         (EN),
    .load       (ext_load_c),
    .is_mul     (IR == OP_MUL),
    .dec        (ext_dec_c),
    .step       (STATE[STEP_W-1:0]),
    .saved_step (saved_step),
    .cnt_zero_c (cnt_zero_c),
    .lo_next_c  (lo_next_c)
  );

  // Mode register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mode_q <= M_NORMAL;
    end else if (EN) begin
      mode_q <= mode_d;
    end
  end

  // Mode transitions
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      M_NORMAL: begin
        if (want_ext_c) begin
          mode_d = M_EXT;
        end else if (halt_c) begin
          mode_d = M_HALT;
        end
      end
      M_EXT: begin
        if (cnt_zero_c) begin
          mode_d = M_NORMAL;
        end
      end
      M_HALT:  mode_d = M_HALT;
      default: mode_d = M_NORMAL;
    endcase
  end

  // IR / STATE / error next values per mode
  always_comb begin
    ir_d    = IR;
    state_d = STATE;
    err_d   = 1'b0;
    case (mode_q)
      M_NORMAL: begin
        if (want_ext_c) begin
          state_d = {2'b10, lo_next_c};
        end else if (halt_c) begin
          err_d = overflow_c;
        end else if (norm_end_c) begin
          ir_d    = DI;
          state_d = '0;
          err_d   = overflow_c;
        end else begin
          state_d = {1'b0, 3'(STATE[STEP_W-1:0] + 3'd1)};
        end
      end
      M_EXT: begin
        if (!cnt_zero_c) begin
          state_d = {2'b10, lo_next_c};
        end else if (saved_step == 3'd7) begin
          // Resuming past step 7 overflows: refetch instead
          ir_d    = DI;
          state_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = {1'b0, 3'(saved_step + 3'd1)};
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IR       <= RST_OPCODE;
      STATE    <= '0;
      SYNC     <= 1'b1;
      EXT_BUSY <= 1'b0;
      SEQ_ERR  <= 1'b0;
    end else if (EN) begin
      IR       <= ir_d;
      STATE    <= state_d;
      SYNC     <= (state_d == '0) && (mode_d != M_EXT);
      EXT_BUSY <= (mode_d == M_EXT);
      SEQ_ERR  <= err_d;
    end
  end

`ifdef SPC700_SLEEP_STOP_EN
  logic halted_q;
  // Sticky halt flag, cleared only by reset
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      halted_q <= 1'b0;
    end else if (EN) begin
      halted_q <= (mode_d == M_HALT);
    end
  end
  assign HALTED = halted_q;
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_spc700_seq.sv
// Testbench for spc700_seq: directed scenarios with literal expectations
// followed by randomized stimulus, all checked against a behavioural model.
module tb_spc700_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b0;
  logic [1:0] STATE_CTRL = 2'b00;
  logic [7:0] DI = 8'h00;
  logic       COND = 1'b0;
  logic [7:0] IR;
  logic [3:0] STATE;
  logic       SYNC;
  logic       EXT_BUSY;
  logic       SEQ_ERR;
  logic       HALTED;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Behavioural model: opcode, step, remaining extended cycles, resume step
  logic [7:0] m_ir = 8'h00;
  int         m_st = 0;
  int         m_left = 0;
  int         m_saved = 0;
  bit         m_err = 1'b0;
  bit         m_halt = 1'b0;
  int         act;

  int         mul_seq[5] = '{8, 8, 9, 10, 11};
  logic [7:0] r_di;
  int         r;

  always #5 CLK = ~CLK;

  spc700_seq dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .EN         (EN),
    .STATE_CTRL (STATE_CTRL),
    .DI         (DI),
    .COND       (COND),
    .IR         (IR),
    .STATE      (STATE),
    .SYNC       (SYNC),
    .EXT_BUSY   (EXT_BUSY),
    .SEQ_ERR    (SEQ_ERR),
    .HALTED     (HALTED)
  );

  // STATE seen with 'left' extended cycles remaining (including this one)
  function automatic int ext_view(input int left);
    return 8 + ((left <= 4) ? (4 - left) : 0);
  endfunction

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc(input logic [1:0] c, input logic cd, input logic [7:0] d, input logic e);
    STATE_CTRL = c;
    COND       = cd;
    DI         = d;
    EN         = e;
    @(posedge CLK);
    #1;
  endtask

  // Reference model, updated on every active edge or reset
  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_ir = 8'h00; m_st = 0; m_left = 0; m_saved = 0; m_err = 0; m_halt = 0;
    end else if (EN) begin
      m_err = 0;
      if (m_halt) begin
        // frozen
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          if (m_saved == 7) begin m_ir = DI; m_st = 0; m_err = 1; end
          else m_st = m_saved + 1;
        end else begin
          m_st = ext_view(m_left);
        end
      end else begin
        case (STATE_CTRL)
          2'b00:   act = 0;
          2'b01:   act = 1;
          2'b10:   act = COND ? 0 : 1;
          default: act = (m_ir == 8'hCF || m_ir == 8'h9E) ? 2 : 0;
        endcase
        if (act == 0 && m_st == 7) begin act = 1; m_err = 1; end
        if (act == 2) begin
          m_saved = m_st;
          m_left  = (m_ir == 8'hCF) ? 5 : 8;
          m_st    = ext_view(m_left);
        end else if (act == 0) begin
          m_st++;
        end else begin
`ifdef SPC700_SLEEP_STOP_EN
          if (m_ir == 8'hEF || m_ir == 8'hFF) m_halt = 1;
          else begin m_ir = DI; m_st = 0; end
`else
          m_ir = DI; m_st = 0;
`endif
        end
      end
    end
  end

  // Compare process: every cycle outside reset
  initial forever begin
    @(negedge CLK);
    if (chk_on && RST_N) begin
      cmp("ir", 32'(IR), 32'(m_ir));
      cmp("state", 32'(STATE), 32'(m_st));
      cmp("sync", 32'(SYNC), 32'(m_left == 0 && m_st == 0));
      cmp("ext_busy", 32'(EXT_BUSY), 32'(m_left > 0));
      cmp("seq_err", 32'(SEQ_ERR), 32'(m_err));
      cmp("halted", 32'(HALTED), 32'(m_halt));
    end
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    cmp("rst_ir", 32'(IR), 32'h00);
    cmp("rst_state", 32'(STATE), 32'h0);
    cmp("rst_sync", 32'(SYNC), 32'h1);
    cmp("rst_busy", 32'(EXT_BUSY), 32'h0);
    cmp("rst_err", 32'(SEQ_ERR), 32'h0);
    cmp("rst_halted", 32'(HALTED), 32'h0);
    RST_N  = 1'b1;
    chk_on = 1'b1;

    // END fetch, then two advances
    cyc(2'b01, 1'b0, 8'hE8, 1'b1);
    cmp("end_ir", 32'(IR), 32'hE8);
    cmp("end_state", 32'(STATE), 32'h0);
    cmp("end_sync", 32'(SYNC), 32'h1);
    cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cmp("adv_state", 32'(STATE), 32'h2);
    cmp("adv_sync", 32'(SYNC), 32'h0);

    // COND false -> end, COND true -> advance
    cyc(2'b01, 1'b0, 8'hF0, 1'b1);
    cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b10, 1'b0, 8'h12, 1'b1);
    cmp("cond0_ir", 32'(IR), 32'h12);
    cmp("cond0_state", 32'(STATE), 32'h0);
    cyc(2'b01, 1'b0, 8'hF0, 1'b1);
    cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b10, 1'b1, 8'h34, 1'b1);
    cmp("cond1_ir", 32'(IR), 32'hF0);
    cmp("cond1_state", 32'(STATE), 32'h2);

    // MUL extended phase from step 3, inputs ignored while busy
    cyc(2'b01, 1'b0, 8'hCF, 1'b1);
    repeat (3) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b11, 1'b0, 8'h55, 1'b1);
    cmp("mul_state0", 32'(STATE), 32'(mul_seq[0]));
    cmp("mul_busy0", 32'(EXT_BUSY), 32'h1);
    for (int i = 1; i < 5; i++) begin
      cyc(2'($urandom), 1'($urandom), 8'($urandom), 1'b1);
      cmp("mul_state", 32'(STATE), 32'(mul_seq[i]));
      cmp("mul_busy", 32'(EXT_BUSY), 32'h1);
    end
    cyc(2'b01, 1'b0, 8'h66, 1'b1);
    cmp("mul_resume", 32'(STATE), 32'h4);
    cmp("mul_done", 32'(EXT_BUSY), 32'h0);
    cmp("mul_ir", 32'(IR), 32'hCF);

    // DIV phase, async reset during the 4th extended cycle
    cyc(2'b01, 1'b0, 8'h9E, 1'b1);
    repeat (3) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b11, 1'b0, 8'h00, 1'b1);
    repeat (3) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cmp("div_state4", 32'(STATE), 32'h8);
    #1 RST_N = 1'b0;
    #1;
    cmp("arst_ir", 32'(IR), 32'h00);
    cmp("arst_state", 32'(STATE), 32'h0);
    cmp("arst_busy", 32'(EXT_BUSY), 32'h0);
    cmp("arst_sync", 32'(SYNC), 32'h1);
    RST_N = 1'b1;

    // Step overflow, then EN low holds everything including SEQ_ERR
    cyc(2'b01, 1'b0, 8'h00, 1'b1);
    repeat (7) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cmp("pre_ovf", 32'(STATE), 32'h7);
    cyc(2'b00, 1'b0, 8'h8F, 1'b1);
    cmp("ovf_ir", 32'(IR), 32'h8F);
    cmp("ovf_state", 32'(STATE), 32'h0);
    cmp("ovf_err", 32'(SEQ_ERR), 32'h1);
    repeat (3) begin
      cyc(2'b01, 1'b1, 8'h11, 1'b0);
      cmp("hold_err", 32'(SEQ_ERR), 32'h1);
      cmp("hold_ir", 32'(IR), 32'h8F);
    end
    cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cmp("err_clear", 32'(SEQ_ERR), 32'h0);
    cmp("post_state", 32'(STATE), 32'h1);

    // MUL from step 7: resume overflows into a refetch
    cyc(2'b01, 1'b0, 8'hCF, 1'b1);
    repeat (7) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b11, 1'b0, 8'h00, 1'b1);
    repeat (4) cyc(2'b00, 1'b0, 8'h00, 1'b1);
    cyc(2'b00, 1'b0, 8'h77, 1'b1);
    cmp("xovf_ir", 32'(IR), 32'h77);
    cmp("xovf_state", 32'(STATE), 32'h0);
    cmp("xovf_err", 32'(SEQ_ERR), 32'h1);

    // STOP end
    cyc(2'b01, 1'b0, 8'hFF, 1'b1);
    cyc(2'b01, 1'b0, 8'h33, 1'b1);
`ifdef SPC700_SLEEP_STOP_EN
    cmp("halt_flag", 32'(HALTED), 32'h1);
    for (int i = 0; i < 20; i++) begin
      cyc(2'($urandom), 1'($urandom), 8'($urandom), 1'b1);
      cmp("halt_ir", 32'(IR), 32'hFF);
      cmp("halt_state", 32'(STATE), 32'h0);
    end
    #1 RST_N = 1'b0;
    #1 RST_N = 1'b1;
`else
    cmp("stop_ir", 32'(IR), 32'h33);
    cmp("stop_halted", 32'(HALTED), 32'h0);
`endif

    // Randomized phase, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    r_di = 8'hCF;
        2:       r_di = 8'h9E;
        default: r_di = 8'($urandom);
      endcase
      r = $urandom_range(0, 99);
      STATE_CTRL = (r < 45) ? 2'b00 : (r < 65) ? 2'b01 : (r < 80) ? 2'b10 : 2'b11;
      COND = 1'($urandom);
      DI   = r_di;
      EN   = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 199) == 0) begin
        #1 RST_N = 1'b0;
        #1 RST_N = 1'b1;
      end
      @(posedge CLK);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
